// File: rtl/dac_spi_multi_out_if.sv
// rtl/dac_spi_multi_out_if.sv - load/status/SPI pin bundle for the multi-channel DAC SPI master
interface dac_spi_multi_out_if #(
  parameter int WORD_BITS = 24,
  parameter int CHANNELS  = 4
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WORD_BITS-1:0] i_Data;
  logic [CHANNELS-1:0]           i_Load;
  logic [CHANNELS-1:0]           o_Pending;
  logic                          o_Busy;
  logic [CH_W-1:0]               o_Channel;
  logic                          o_Frame_Done;
  logic                          o_SPI_CS;
  logic                          o_SPI_Clock;
  logic                          o_SPI_Data;

  modport master (
    output i_Data, i_Load,
    input  o_Pending, o_Busy, o_Channel, o_Frame_Done, o_SPI_CS, o_SPI_Clock, o_SPI_Data
  );

  modport slave (
    input  i_Data, i_Load,
    output o_Pending, o_Busy, o_Channel, o_Frame_Done, o_SPI_CS, o_SPI_Clock, o_SPI_Data
  );
endinterface

// File: rtl/dac_spi_multi_out.sv
// rtl/dac_spi_multi_out.sv - multi-channel SPI DAC writer, latest-value holding regs, round-robin frames
module dac_spi_multi_out #(
  parameter int WORD_BITS = 24,
  parameter int CHANNELS  = 4,
  parameter int CLK_DIV   = 5,
  parameter bit CPOL      = 1'b1,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CS_GAP    = 2
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  dac_spi_multi_out_if.slave bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WORD_BITS);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                             state_q;
  logic [CHANNELS-1:0][WORD_BITS-1:0] hold_q;
  logic [CHANNELS-1:0]                pend_q;
  logic [WORD_BITS-1:0]               sr_q;
  logic [DIV_W-1:0]                   div_q;
  logic [BIT_W-1:0]                   bit_q;
  logic                               phase_q;
  logic [GAP_W-1:0]                   gap_q;
  logic [CH_W-1:0]                    rr_q, chan_q;
  logic                               cs_q, sclk_q, mosi_q, busy_q, done_q;

  logic                               sel_vld_d;
  logic [CH_W-1:0]                    sel_ch_d, rr_d;
  logic [CH_W:0]                      arb_idx_d;
  logic [CHANNELS-1:0]                clr_d;
  logic                               half_wrap;

  assign half_wrap = (div_q == DIV_W'(CLK_DIV - 1));

  function automatic logic word_bit(input logic [WORD_BITS-1:0] w, input logic [BIT_W-1:0] b);
    logic [BIT_W-1:0] idx;
    idx = MSB_FIRST ? (BIT_W'(WORD_BITS - 1) - b) : b;
    return w[idx];
  endfunction

  // Descending scan so the smallest offset from the RR pointer wins.
  always_comb begin
    sel_vld_d = 1'b0;
    sel_ch_d  = '0;
    arb_idx_d = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      arb_idx_d = {1'b0, rr_q} + (CH_W + 1)'(i);
      if (arb_idx_d >= (CH_W + 1)'(CHANNELS)) arb_idx_d = arb_idx_d - (CH_W + 1)'(CHANNELS);
      if (pend_q[arb_idx_d[CH_W-1:0]]) begin
        sel_vld_d = 1'b1;
        sel_ch_d  = arb_idx_d[CH_W-1:0];
      end
    end
    rr_d  = (sel_ch_d == CH_W'(CHANNELS - 1)) ? '0 : sel_ch_d + CH_W'(1);
    clr_d = '0;
    if (state_q == IDLE && sel_vld_d) clr_d[sel_ch_d] = 1'b1;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      pend_q  <= '0;
      sr_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      gap_q   <= '0;
      rr_q    <= '0;
      chan_q  <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= CPOL;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        if (bus.i_Load[n]) hold_q[n] <= bus.i_Data[n*WORD_BITS +: WORD_BITS];
      end
      // A load on the channel being picked re-arms it with the new word.
      pend_q <= (pend_q & ~clr_d) | bus.i_Load;
      div_q  <= (state_q == IDLE || half_wrap) ? '0 : div_q + DIV_W'(1);

      case (state_q)
        IDLE: begin
          if (sel_vld_d) begin
            sr_q    <= hold_q[sel_ch_d];
            mosi_q  <= word_bit(hold_q[sel_ch_d], '0);
            chan_q  <= sel_ch_d;
            rr_q    <= rr_d;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            bit_q   <= '0;
            phase_q <= 1'b0;
            state_q <= SETUP;
          end
        end
        SETUP: if (half_wrap) state_q <= SHIFT;
        SHIFT: begin
          if (half_wrap) begin
            if (!phase_q) begin
              sclk_q  <= ~CPOL;
              phase_q <= 1'b1;
            end else begin
              sclk_q  <= CPOL;
              phase_q <= 1'b0;
              if (bit_q == BIT_W'(WORD_BITS - 1)) begin
                state_q <= HOLD;
              end else begin
                bit_q  <= bit_q + BIT_W'(1);
                mosi_q <= word_bit(sr_q, bit_q + BIT_W'(1));
              end
            end
          end
        end
        HOLD: begin
          if (half_wrap) begin
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
            gap_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (half_wrap) begin
            if (gap_q == GAP_W'(CS_GAP - 1)) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_Pending    = pend_q;
  assign bus.o_Busy       = busy_q;
  assign bus.o_Channel    = chan_q;
  assign bus.o_Frame_Done = done_q;
  assign bus.o_SPI_CS     = cs_q;
  assign bus.o_SPI_Clock  = sclk_q;
  assign bus.o_SPI_Data   = mosi_q;
endmodule

// File: tb/tb_dac_spi_multi_out.sv
// tb/tb_dac_spi_multi_out.sv - random + directed bench with a frame-level reference model
module tb_dac_spi_multi_out;
  localparam int LOW_A = (2*24 + 2) * 5;
  localparam int PER_A = (2*24 + 2 + 2) * 5 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_spi_multi_out_if #(.WORD_BITS(24), .CHANNELS(4)) ifa ();
  dac_spi_multi_out_if #(.WORD_BITS(16), .CHANNELS(2)) ifb ();

  dac_spi_multi_out #(.WORD_BITS(24), .CHANNELS(4), .CLK_DIV(5), .CPOL(1'b1),
                      .MSB_FIRST(1'b1), .CS_GAP(2))
    u_a (.i_Clock(clk), .i_Reset(rst), .bus(ifa.slave));

  dac_spi_multi_out #(.WORD_BITS(16), .CHANNELS(2), .CLK_DIV(1), .CPOL(1'b0),
                      .MSB_FIRST(1'b0), .CS_GAP(1))
    u_b (.i_Clock(clk), .i_Reset(rst), .bus(ifb.slave));

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    int          ch;
    logic [23:0] w;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] m_hold[4];
  logic [3:0]  m_pend = '0;
  int          m_rr = 0;
  int          m_free = 0;
  int          m_arb = -1000;
  int          cyc = 0;
  int          c;

  // Reference model: latest-value slots, RR choice when idle, fixed frame period.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_pend = '0; m_rr = 0; m_free = 0; m_arb = -1000;
        exp_q.delete();
      end else begin
        if (cyc >= m_free && m_pend != 0) begin
          for (int i = 0; i < 4; i++) begin
            c = (m_rr + i) % 4;
            if (m_pend[c]) begin
              exp_q.push_back('{c, m_hold[c], cyc});
              m_pend[c] = 1'b0;
              m_rr   = (c + 1) % 4;
              m_arb  = cyc;
              m_free = cyc + PER_A;
              break;
            end
          end
        end
        for (int n = 0; n < 4; n++) begin
          if (ifa.i_Load[n]) begin
            m_hold[n] = ifa.i_Data[n*24 +: 24];
            m_pend[n] = 1'b1;
          end
        end
      end
    end
  end

  logic        p_cs, p_sclk, cs, sc, sd, fd, rise;
  logic        in_frame = 1'b0;
  logic [23:0] word, last_word;
  int          edges, fall_cyc, last_ch, n_falls = 0, n_frames = 0;
  exp_t        cur;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0; p_cs = 1'b1; p_sclk = 1'b1;
      end else begin
        cs = ifa.o_SPI_CS; sc = ifa.o_SPI_Clock; sd = ifa.o_SPI_Data; fd = ifa.o_Frame_Done;
        rise = !p_cs && cs;
        check("pending", 32'(ifa.o_Pending), 32'(m_pend));
        check("busy", 32'(ifa.o_Busy), 32'(cyc >= m_arb && cyc < m_free - 1));
        if (p_cs && !cs) begin
          n_falls++;
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("cs_fall_chan", 32'(ifa.o_Channel), 32'(cur.ch));
            check("cs_fall_cycle", 32'(cyc), 32'(cur.cyc));
            in_frame = 1'b1; fall_cyc = cyc; edges = 0; word = '0;
          end
        end
        if (!cs && !p_cs && p_sclk && !sc) begin
          edges++;
          word = {word[22:0], sd};
        end
        if (cs) check("idle_pins", {30'b0, sc, sd}, 32'd2);
        if (rise && in_frame) begin
          check("frame_word", 32'(word), 32'(cur.w));
          check("sclk_edges", 32'(edges), 32'd24);
          check("cs_low_cycles", 32'(cyc - fall_cyc), 32'(LOW_A));
          check("done_at_rise", 32'(fd), 32'd1);
          last_word = word; last_ch = cur.ch; n_frames++;
          in_frame = 1'b0;
        end
        if (fd) check("done_only_at_rise", 32'(rise), 32'd1);
        p_cs = cs; p_sclk = sc;
      end
    end
  end

  task automatic load_a(input logic [3:0] m, input logic [95:0] d);
    @(negedge clk);
    ifa.i_Data = d; ifa.i_Load = m;
    @(negedge clk);
    ifa.i_Load = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cyc >= m_free && m_pend == 0 && !in_frame) return;
    end
    check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_b(input logic ch, input logic [15:0] v);
    int low, rises, dones;
    logic [15:0] w;
    logic ps;
    @(negedge clk);
    ifb.i_Data = ch ? {v, 16'h0} : {16'h0, v};
    ifb.i_Load = ch ? 2'b10 : 2'b01;
    @(negedge clk);
    ifb.i_Load = '0;
    low = 0; rises = 0; dones = 0; w = '0; ps = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!ifb.o_SPI_CS) begin
        low++;
        if (!ps && ifb.o_SPI_Clock) begin
          rises++;
          w = {ifb.o_SPI_Data, w[15:1]};
        end
      end else begin
        check("b_idle_sclk", 32'(ifb.o_SPI_Clock), 32'd0);
      end
      if (ifb.o_Frame_Done) dones++;
      ps = ifb.o_SPI_Clock;
    end
    check("b_word", 32'(w), 32'(v));
    check("b_cs_low", 32'(low), 32'd34);
    check("b_rises", 32'(rises), 32'd16);
    check("b_dones", 32'(dones), 32'd1);
    check("b_chan", 32'(ifb.o_Channel), 32'(ch));
    check("b_pending", 32'(ifb.o_Pending), 32'd0);
  endtask

  int f0, falls0;
  logic [23:0] r0;

  initial begin
    ifa.i_Data = '0; ifa.i_Load = '0;
    ifb.i_Data = '0; ifb.i_Load = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_a_cs", 32'(ifa.o_SPI_CS), 32'd1);
    check("rst_a_sclk", 32'(ifa.o_SPI_Clock), 32'd1);
    check("rst_a_data", 32'(ifa.o_SPI_Data), 32'd0);
    check("rst_a_busy", 32'(ifa.o_Busy), 32'd0);
    check("rst_a_pend", 32'(ifa.o_Pending), 32'd0);
    check("rst_a_chan", 32'(ifa.o_Channel), 32'd0);
    check("rst_a_done", 32'(ifa.o_Frame_Done), 32'd0);
    check("rst_b_sclk", 32'(ifb.o_SPI_Clock), 32'd0);
    check("rst_b_cs", 32'(ifb.o_SPI_CS), 32'd1);
    rst = 1'b0;

    // T1: single word on channel 0
    load_a(4'b0001, {72'h0, 24'h123456});
    wait_idle();
    check("t1_word", 32'(last_word), 32'h123456);
    check("t1_chan", 32'(last_ch), 32'd0);
    check("t1_pending", 32'(ifa.o_Pending), 32'd0);

    // T2: all channels at once
    f0 = n_frames;
    load_a(4'b1111, {$urandom, $urandom, $urandom});
    wait_idle();
    check("t2_frames", 32'(n_frames - f0), 32'd4);

    // T3: double reload of ch1 during ch0 frame
    f0 = n_frames;
    load_a(4'b0001, {72'h0, 24'(($urandom))});
    repeat (20) @(negedge clk);
    load_a(4'b0010, {48'h0, 24'hAAAAAA, 24'h0});
    load_a(4'b0010, {48'h0, 24'h555555, 24'h0});
    wait_idle();
    check("t3_frames", 32'(n_frames - f0), 32'd2);
    check("t3_word", 32'(last_word), 32'h555555);

    // T4: reload ch2 on the cycle it is chosen
    f0 = n_frames;
    r0 = 24'($urandom);
    @(negedge clk); ifa.i_Data = {24'h0, 24'h0F0F0F, 48'h0}; ifa.i_Load = 4'b0100;
    @(negedge clk); ifa.i_Data = {24'h0, r0, 48'h0};        ifa.i_Load = 4'b0100;
    @(negedge clk); ifa.i_Load = '0;
    wait_idle();
    check("t4_frames", 32'(n_frames - f0), 32'd2);
    check("t4_word", 32'(last_word), 32'(r0));

    // T5: asynchronous reset at bit 10
    load_a(4'b0001, {72'h0, 24'(($urandom))});
    for (int i = 0; i < 100 && ifa.o_SPI_CS; i++) @(negedge clk);
    check("t5_cs_fell", 32'(ifa.o_SPI_CS), 32'd0);
    repeat (21 * 5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_async_cs", 32'(ifa.o_SPI_CS), 32'd1);
    check("t5_async_sclk", 32'(ifa.o_SPI_Clock), 32'd1);
    check("t5_async_data", 32'(ifa.o_SPI_Data), 32'd0);
    check("t5_async_done", 32'(ifa.o_Frame_Done), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    falls0 = n_falls;
    repeat (400) @(negedge clk);
    check("t5_no_resend", 32'(n_falls), 32'(falls0));
    check("t5_pending", 32'(ifa.o_Pending), 32'd0);

    // T6: idle-low, LSB-first, divide-by-one instance
    run_b(1'b0, 16'h8001);
    run_b(1'b1, 16'($urandom));

    // Random load traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        ifa.i_Data = {$urandom, $urandom, $urandom};
        ifa.i_Load = 4'($urandom_range(1, 15));
      end else begin
        ifa.i_Load = '0;
      end
    end
    @(negedge clk); ifa.i_Load = '0;
    wait_idle();
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
